// File: rtl/date_display_scan.sv
// Four-digit multiplexed seven-segment scanner for a month/day or year display.
// Optional leading-zero blanking on positions 0..2 is enabled by defining DISP_LZB_EN.
module date_display_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk_out,
  input  logic       rst_n,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic       switch,
  output logic [3:0] ssd_ctl,
  output logic [7:0] segs
);

  localparam logic [19:0] LastCount = 20'(SCAN_DIV - 1);
  localparam logic [3:0]  BlankCode = 4'hF;

  // Prescaler and slot index
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        tick;
  logic        frame_end;

  // Shadow registers: the display only ever reads these
  logic [3:0] sh0_q, sh1_q, sh2_q, sh3_q;
  logic [3:0] sh0_d, sh1_d, sh2_d, sh3_d;
  logic       sw_q, sw_d;
  logic       loaded_q, loaded_d;

  // Output registers
  logic [3:0] ssd_ctl_q, ssd_ctl_d;
  logic [7:0] segs_q, segs_d;

  // Decode-stage intermediates
  logic [3:0] cur_digit;
  logic [2:0] lzb;
  logic       cur_blank;
  logic [6:0] cur_segs;
  logic       dp_n;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b1111111;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

`ifdef DISP_LZB_EN
  // A digit that shows nothing: a zero or a non-BCD code
  function automatic logic is_dark(input logic [3:0] d);
    return (d == 4'd0) || (d > 4'd9);
  endfunction
`endif

  always_comb begin
    tick      = (cnt_q == LastCount);
    cnt_d     = tick ? 20'd0 : cnt_q + 20'd1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    frame_end = tick && (idx_q == 2'd3);
  end

  always_comb begin
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    sh3_d    = sh3_q;
    sw_d     = sw_q;
    loaded_d = loaded_q;
    if (frame_end) begin
      sh0_d    = in0;
      sh1_d    = in1;
      sh2_d    = in2;
      sh3_d    = in3;
      sw_d     = switch;
      loaded_d = 1'b1;
    end
  end

  always_comb begin
`ifdef DISP_LZB_EN
    lzb[0] = (sh0_q == 4'd0);
    lzb[1] = (sh1_q == 4'd0) && is_dark(sh0_q);
    lzb[2] = (sh2_q == 4'd0) && is_dark(sh0_q) && is_dark(sh1_q);
`else
    lzb    = 3'b000;
`endif
  end

  always_comb begin
    cur_digit = BlankCode;
    cur_blank = 1'b0;
    unique case (idx_q)
      2'd0: begin
        cur_digit = sh0_q;
        cur_blank = lzb[0];
      end
      2'd1: begin
        cur_digit = sh1_q;
        cur_blank = lzb[1];
      end
      2'd2: begin
        cur_digit = sh2_q;
        cur_blank = lzb[2];
      end
      2'd3: begin
        cur_digit = sh3_q;
        cur_blank = 1'b0;
      end
    endcase

    cur_segs = cur_blank ? 7'b1111111 : seg7(cur_digit);
    // Separator stays dark until real data has been loaded, so post-reset frames are fully blank
    dp_n      = ~(loaded_q && (idx_q == 2'd1) && !sw_q);
    ssd_ctl_d = ~(4'b1000 >> idx_q);
    segs_d    = {cur_segs, dp_n};
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 20'd0;
      idx_q     <= 2'd0;
      sh0_q     <= BlankCode;
      sh1_q     <= BlankCode;
      sh2_q     <= BlankCode;
      sh3_q     <= BlankCode;
      sw_q      <= 1'b0;
      loaded_q  <= 1'b0;
      ssd_ctl_q <= 4'b1111;
      segs_q    <= 8'hFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh0_q     <= sh0_d;
      sh1_q     <= sh1_d;
      sh2_q     <= sh2_d;
      sh3_q     <= sh3_d;
      sw_q      <= sw_d;
      loaded_q  <= loaded_d;
      ssd_ctl_q <= ssd_ctl_d;
      segs_q    <= segs_d;
    end
  end

  assign ssd_ctl = ssd_ctl_q;
  assign segs    = segs_q;

endmodule

// File: tb/tb_date_display_scan.sv
// Directed bench for date_display_scan at SCAN_DIV = 4; expected slot outputs are
// queued when stimulus is driven and popped when the matching slot is on display.
module tb_date_display_scan;

  logic       clk_out;
  logic       rst_n;
  logic [3:0] in0, in1, in2, in3;
  logic       switch;
  logic [3:0] ssd_ctl;
  logic [7:0] segs;

  int errors = 0;
  int checks = 0;
  int ecount;

  typedef struct {
    string      tag;
    logic [3:0] ctl;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];

  date_display_scan #(
    .SCAN_DIV(4)
  ) dut (
    .clk_out(clk_out),
    .rst_n  (rst_n),
    .in0    (in0),
    .in1    (in1),
    .in2    (in2),
    .in3    (in3),
    .switch (switch),
    .ssd_ctl(ssd_ctl),
    .segs   (segs)
  );

  initial clk_out = 1'b0;
  always #5 clk_out = ~clk_out;

  // Edges since reset release; slot s of frame k is on the outputs after edges 16k+4s+1..+4
  always @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) ecount <= 0;
    else        ecount <= ecount + 1;
  end

  task automatic push(input string tag, input logic [3:0] ctl, input logic [7:0] seg);
    exp_t e;
    e.tag = tag;
    e.ctl = ctl;
    e.seg = seg;
    sb.push_back(e);
  endtask

  task automatic push_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    push({tag, "_p0"}, 4'b0111, s0);
    push({tag, "_p1"}, 4'b1011, s1);
    push({tag, "_p2"}, 4'b1101, s2);
    push({tag, "_p3"}, 4'b1110, s3);
  endtask

  task automatic wait_to(input int target);
    int guard;
    guard = 0;
    while (ecount < target && guard < 2000) begin
      @(posedge clk_out);
      #1;
      guard++;
    end
    if (ecount != target) begin
      checks++;
      errors++;
      $error("FAIL wait_to edge count observed=%0d expected=%0d", ecount, target);
    end
  endtask

  task automatic check_now(input string tag, input logic [3:0] ctl, input logic [7:0] seg);
    checks++;
    assert (ssd_ctl === ctl) else begin
      errors++;
      $error("FAIL %s ssd_ctl observed=%b expected=%b", tag, ssd_ctl, ctl);
    end
    checks++;
    assert (segs === seg) else begin
      errors++;
      $error("FAIL %s segs observed=%h expected=%h", tag, segs, seg);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard empty observed=0 expected=1 entries");
    end else begin
      e = sb.pop_front();
      check_now(e.tag, e.ctl, e.seg);
    end
  endtask

  task automatic check_slot(input int frame, input int slot);
    wait_to(16 * frame + 4 * slot + 2);
    check_pop();
  endtask

  initial begin
    rst_n  = 1'b1;
    in0    = 4'd1;
    in1    = 4'd2;
    in2    = 4'd1;
    in3    = 4'd5;
    switch = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk_out);
    check_now("in_reset", 4'b1111, 8'hFF);
    push_frame("blank_f0", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    push_frame("md_f1", 8'h9F, 8'h24, 8'h9F, 8'h49);
    rst_n = 1'b1;

    for (int s = 0; s < 4; s++) check_slot(0, s);

    check_slot(1, 0);
    check_slot(1, 1);
    // Change mid-frame; position 3 must keep the old digit until the next boundary
    in3 = 4'd6;
    push_frame("tear_f2", 8'h9F, 8'h24, 8'h9F, 8'h41);
    check_slot(1, 2);
    check_slot(1, 3);

    for (int s = 0; s < 4; s++) check_slot(2, s);

    in0    = 4'd0;
    in1    = 4'd0;
    in2    = 4'd0;
    in3    = 4'd7;
    switch = 1'b1;
`ifdef DISP_LZB_EN
    push_frame("year_f3", 8'hFF, 8'hFF, 8'hFF, 8'h1F);
`else
    push_frame("year_f3", 8'h03, 8'h03, 8'h03, 8'h1F);
`endif
    for (int s = 0; s < 4; s++) check_slot(3, s);

    in0    = 4'd3;
    in1    = 4'd1;
    in2    = 4'hA;
    in3    = 4'd9;
    switch = 1'b0;
    push_frame("bad_f4", 8'h0D, 8'h9E, 8'hFF, 8'h09);
    for (int s = 0; s < 4; s++) check_slot(4, s);

    // Mid-frame reset while position 2 is on display
    wait_to(16 * 5 + 4 * 2 + 2);
    check_now("pre_rst_p2", 4'b1101, 8'hFF);
    rst_n = 1'b0;
    #1;
    check_now("async_rst", 4'b1111, 8'hFF);
    repeat (2) @(negedge clk_out);
    check_now("rst_held", 4'b1111, 8'hFF);
    push("rst_rel_p0", 4'b0111, 8'hFF);
    push("rst_rel_p1", 4'b1011, 8'hFF);
    push("rst_f1_p0", 4'b0111, 8'h0D);
    rst_n = 1'b1;
    wait_to(4);
    check_pop();
    wait_to(6);
    check_pop();
    wait_to(18);
    check_pop();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0 entries", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
